// File: rtl/morse_msg_driver.sv
// morse_msg_driver: serialises a programmable Morse message onto one line.
// Ports: clk, rst_n, start, msg, msg_len, rep_en -> dataOut, busy, done, sym_idx.
module morse_msg_driver #(
  parameter int UNIT_CYCLES = 4,
  parameter int MAX_SYMBOLS = 16,
  parameter int LEN_W = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2*MAX_SYMBOLS-1:0] msg,
  input  logic [LEN_W-1:0]         msg_len,
  input  logic                     rep_en,
  output logic                     dataOut,
  output logic                     busy,
  output logic                     done,
  output logic [LEN_W-1:0]         sym_idx
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UW-1:0] U_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_SYMBOLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_GAP,
    S_DONE
  } state_t;

  state_t                   state;
  logic [2*MAX_SYMBOLS-1:0] msg_q;
  logic [LEN_W-1:0]         len_q;
  logic [UW-1:0]            unit_cnt;
  logic [2:0]               units_left;
  // wrap: the current GAP is the inter-pass word gap of repeat mode
  logic                     wrap;
  // pend: start seen during the DONE cycle, launched from IDLE
  logic                     pend;

  logic [LEN_W-1:0] len_in;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] nxt_idx;
  logic [1:0]       nxt_code;
  logic             unit_end;
  logic             phase_end;

  // Dots and dashes key the line; both gap codes keep it low.
  function automatic state_t code_state(input logic [1:0] c);
    return c[1] ? S_GAP : S_ON;
  endfunction

  // units_left is loaded with (duration in units - 1)
  function automatic logic [2:0] code_units(input logic [1:0] c);
    logic [2:0] u;
    unique case (c)
      2'b00: u = 3'd0;
      2'b01: u = 3'd2;
      2'b10: u = 3'd1;
      2'b11: u = 3'd5;
    endcase
    return u;
  endfunction

  always_comb begin
    len_in    = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
    last_idx  = len_q - LEN_W'(1);
    nxt_idx   = wrap ? '0 : sym_idx + LEN_W'(1);
    unit_end  = (unit_cnt == U_LAST);
    phase_end = unit_end && (units_left == 3'd0);
    nxt_code  = 2'b00;
    for (int i = 0; i < MAX_SYMBOLS; i++) begin
      if (nxt_idx == LEN_W'(i)) nxt_code = msg_q[2*i +: 2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      msg_q      <= '0;
      len_q      <= '0;
      unit_cnt   <= '0;
      units_left <= '0;
      wrap       <= 1'b0;
      pend       <= 1'b0;
      dataOut    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sym_idx    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          pend <= 1'b0;
          if (start || pend) begin
            msg_q    <= msg;
            len_q    <= len_in;
            unit_cnt <= '0;
            sym_idx  <= '0;
            wrap     <= 1'b0;
            if (len_in == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              busy       <= 1'b1;
              state      <= code_state(msg[1:0]);
              units_left <= code_units(msg[1:0]);
              dataOut    <= ~msg[1];
            end
          end
        end
        S_ON, S_OFF, S_GAP: begin
          unit_cnt <= unit_end ? '0 : unit_cnt + UW'(1);
          if (!phase_end) begin
            if (unit_end) units_left <= units_left - 3'd1;
          end else if (state == S_ON) begin
            state      <= S_OFF;
            units_left <= 3'd0;
            dataOut    <= 1'b0;
          end else if (wrap || (sym_idx != last_idx)) begin
            wrap       <= 1'b0;
            sym_idx    <= nxt_idx;
            state      <= code_state(nxt_code);
            units_left <= code_units(nxt_code);
            dataOut    <= ~nxt_code[1];
          end else if (rep_en) begin
            wrap       <= 1'b1;
            state      <= S_GAP;
            units_left <= 3'd5;
          end else begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            sym_idx <= '0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          pend  <= start;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_msg_driver.sv
// tb_morse_msg_driver: randomized scoreboard bench for morse_msg_driver.
// A cycle-level expectation is built from the Morse timing rules.
module tb_morse_msg_driver;

  localparam int UC = 2;
  localparam int MS = 16;
  localparam int LW = $clog2(MS + 1);

  typedef struct packed {
    logic          d;
    logic          b;
    logic          dn;
    logic [LW-1:0] idx;
    logic          last;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2*MS-1:0] msg = '0;
  logic [LW-1:0] msg_len = '0;
  logic          rep_en = 1'b0;
  logic          dataOut;
  logic          busy;
  logic          done;
  logic [LW-1:0] sym_idx;

  morse_msg_driver #(
    .UNIT_CYCLES(UC),
    .MAX_SYMBOLS(MS),
    .LEN_W(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .msg(msg),
    .msg_len(msg_len),
    .rep_en(rep_en),
    .dataOut(dataOut),
    .busy(busy),
    .done(done),
    .sym_idx(sym_idx)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  ent_t exp_q[$];
  ent_t plan[$];
  ent_t pass_q[$];
  ent_t cur = '0;
  bit   pend = 1'b0;
  int   m_len = 0;

  int hi_runs[$];
  int last_busy_run = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int rise_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Expand a message into per-cycle expectations for one pass.
  function automatic void build(input logic [2*MS-1:0] m, input int len);
    ent_t e;
    logic [1:0] c;
    int on_u;
    int off_u;
    pass_q.delete();
    m_len = (len > MS) ? MS : len;
    for (int i = 0; i < m_len; i++) begin
      c = 2'(m >> (2 * i));
      on_u  = (c == 2'b00) ? 1 : (c == 2'b01) ? 3 : 0;
      off_u = (c == 2'b10) ? 2 : (c == 2'b11) ? 6 : 1;
      for (int k = 0; k < (on_u + off_u) * UC; k++) begin
        e = '0;
        e.b = 1'b1;
        e.idx = LW'(i);
        e.d = (k < on_u * UC);
        pass_q.push_back(e);
      end
    end
    if (pass_q.size() != 0) begin
      e = pass_q.pop_back();
      e.last = 1'b1;
      pass_q.push_back(e);
    end
  endfunction

  task automatic tick(input bit st, input bit rep, input bit rs);
    ent_t e;
    start = st;
    rep_en = rep;
    rst_n = rs;
    @(posedge clk);
    #1;
    if (!rs) begin
      plan.delete();
      pend = 1'b0;
      cur = '0;
    end else begin
      if (cur.last) begin
        if (rep) begin
          for (int k = 0; k < 6 * UC; k++) begin
            e = '0;
            e.b = 1'b1;
            e.idx = LW'(m_len - 1);
            plan.push_back(e);
          end
          foreach (pass_q[i]) plan.push_back(pass_q[i]);
        end else begin
          e = '0;
          e.dn = 1'b1;
          plan.push_back(e);
        end
      end else if (cur.dn) begin
        pend = st;
      end else if (!cur.b && (st || pend)) begin
        pend = 1'b0;
        build(msg, int'(msg_len));
        if (pass_q.size() == 0) begin
          e = '0;
          e.dn = 1'b1;
          plan.push_back(e);
        end else begin
          foreach (pass_q[i]) plan.push_back(pass_q[i]);
        end
      end
      if (plan.size() != 0) cur = plan.pop_front();
      else cur = '0;
    end
    exp_q.push_back(cur);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((plan.size() != 0 || cur.b || cur.dn || pend) && n < 4000) begin
      tick(1'b0, 1'b0, 1'b1);
      n++;
    end
    if (n >= 4000) check("drain_bound", n, 0);
    tick(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  initial begin
    ent_t e;
    int cyc;
    int brun;
    int hrun;
    bit pbusy;
    cyc = 0;
    brun = 0;
    hrun = 0;
    pbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("cycle", {24'd0, dataOut, busy, done, sym_idx},
              {24'd0, e.d, e.b, e.dn, e.idx});
      end
      if (busy === 1'b1) begin
        if (!pbusy) rise_cyc = cyc;
        brun++;
      end else if (done === 1'b1) begin
        last_busy_run = brun;
        brun = 0;
        done_cnt++;
        last_done_cyc = cyc;
      end else begin
        brun = 0;
      end
      pbusy = (busy === 1'b1);
      if (dataOut === 1'b1) hrun++;
      else if (hrun > 0) begin
        hi_runs.push_back(hrun);
        hrun = 0;
      end
      cyc++;
    end
  end

  logic [2*MS-1:0] sos;
  int sos_codes[11] = '{0, 0, 0, 2, 1, 1, 1, 2, 0, 0, 0};
  int sos_runs[9] = '{UC, UC, UC, 3*UC, 3*UC, 3*UC, UC, UC, UC};

  task automatic check_sos_runs(input string nm);
    check({nm, "_nruns"}, hi_runs.size(), 9);
    for (int i = 0; i < 9 && i < hi_runs.size(); i++)
      check({nm, "_run"}, hi_runs[i], sos_runs[i]);
  endtask

  task automatic launch_sos();
    msg = sos;
    msg_len = LW'(11);
    hi_runs.delete();
    tick(1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    int dc;
    int len;
    int dur;
    bit rep;

    sos = '0;
    foreach (sos_codes[i]) sos[2*i +: 2] = 2'(sos_codes[i]);

    // reset and idle
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    repeat (8) tick(1'b0, 1'b0, 1'b1);

    // single-shot SOS
    launch_sos();
    drain();
    check("sos_busy", last_busy_run, 28 * UC);
    check_sos_runs("sos");

    // zero length
    dc = done_cnt;
    msg_len = '0;
    tick(1'b1, 1'b0, 1'b1);
    drain();
    check("zero_busy", last_busy_run, 0);
    check("zero_done", done_cnt - dc, 1);

    // repeat, rep_en cleared during the second pass
    msg = sos;
    msg_len = LW'(11);
    tick(1'b1, 1'b1, 1'b1);
    repeat (28 * UC + 6 * UC + 10) tick(1'b0, 1'b1, 1'b1);
    drain();
    check("rep_busy", last_busy_run, 62 * UC);

    // start while busy is ignored, msg changes ignored
    launch_sos();
    repeat (9) tick(1'b0, 1'b0, 1'b1);
    msg = 32'hffff_ffff;
    msg_len = LW'(3);
    tick(1'b1, 1'b0, 1'b1);
    drain();
    check("hs_busy", last_busy_run, 28 * UC);
    check_sos_runs("hs");

    // start asserted only in the DONE cycle
    launch_sos();
    n = 0;
    while (!cur.dn && n < 500) begin
      tick(1'b0, 1'b0, 1'b1);
      n++;
    end
    check("done_seen", cur.dn, 1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("restart_lat", rise_cyc - last_done_cyc, 2);
    drain();

    // reset during the second dash
    launch_sos();
    n = 0;
    while (!(cur.idx == LW'(5) && cur.d) && n < 500) begin
      tick(1'b0, 1'b0, 1'b1);
      n++;
    end
    check("dash2_seen", cur.idx, 5);
    dc = done_cnt;
    tick(1'b0, 1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 1'b1);
    check("abort_no_done", done_cnt - dc, 0);
    launch_sos();
    drain();
    check("post_rst_busy", last_busy_run, 28 * UC);
    check_sos_runs("post_rst");

    // random messages, random restarts, live rep_en
    for (int it = 0; it < 25; it++) begin
      rep = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 20);
      dur = $urandom_range(0, 250);
      msg = $urandom();
      msg_len = LW'(len);
      tick(1'b1, rep, 1'b1);
      for (int j = 0; j < dur; j++) begin
        if ($urandom_range(0, 15) == 0) msg = $urandom();
        if ($urandom_range(0, 15) == 0) msg_len = LW'($urandom_range(0, 20));
        if ($urandom_range(0, 40) == 0) rep = ~rep;
        tick($urandom_range(0, 9) == 0, rep, 1'b1);
      end
      drain();
      repeat ($urandom_range(0, 3)) tick(1'b0, 1'b0, 1'b1);
    end

    repeat (2) tick(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
